// File: rtl/event_delay_chain.sv
// Cycle-counted producer/consumer event chain: start -> delayed e1_pulse -> latched
// a_level -> delayed e2_pulse with a sticky finished flag. All outputs are registered.
module event_delay_chain #(
    parameter int DELAY1 = 100,
    parameter int DELAY2 = 100,
    parameter int CNT_W  = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic clear,
    output logic e1_pulse,
    output logic a_level,
    output logic e2_pulse,
    output logic finished,
    output logic busy,
    output logic overrun
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARM   = 3'd1;
    localparam logic [2:0] S_WAIT1 = 3'd2;
    localparam logic [2:0] S_LATCH = 3'd3;
    localparam logic [2:0] S_WAIT2 = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [CNT_W-1:0] LOAD1   = CNT_W'(DELAY1);
    localparam logic [CNT_W-1:0] LOAD2   = CNT_W'(DELAY2 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

    if (DELAY1 < 0 || DELAY1 > CNT_MAX) begin : g_bad_delay1
        $error("event_delay_chain: DELAY1=%0d outside 0..%0d", DELAY1, CNT_MAX);
    end
    if (DELAY2 < 1 || DELAY2 > CNT_MAX) begin : g_bad_delay2
        $error("event_delay_chain: DELAY2=%0d outside 1..%0d", DELAY2, CNT_MAX);
    end

    logic [2:0]       state_reg, state_next;
    logic [CNT_W-1:0] counter_reg, counter_next;
    logic             e1_pulse_reg, e1_pulse_next;
    logic             e2_pulse_reg, e2_pulse_next;
    logic             a_level_reg, a_level_next;
    logic             a_prev_reg;
    logic             finished_reg, finished_next;
    logic             busy_reg, busy_next;
    logic             overrun_reg, overrun_next;
    logic             a_rise;
    logic             a_fall;

    assign a_rise = a_level_reg & ~a_prev_reg;
    assign a_fall = ~a_level_reg & a_prev_reg;

    always_comb begin
        state_next    = state_reg;
        counter_next  = counter_reg;
        e1_pulse_next = 1'b0;
        e2_pulse_next = 1'b0;
        a_level_next  = a_level_reg;
        finished_next = finished_reg;
        overrun_next  = overrun_reg | (start & busy_reg);

        if (clear) begin
            state_next    = S_IDLE;
            counter_next  = '0;
            a_level_next  = 1'b0;
            finished_next = 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        state_next    = S_ARM;
                        a_level_next  = 1'b0;
                        finished_next = 1'b0;
                    end
                end
                S_ARM: begin
                    counter_next = LOAD1;
                    state_next   = S_WAIT1;
                end
                S_WAIT1: begin
                    if (counter_reg == '0) begin
                        e1_pulse_next = 1'b1;
                        state_next    = S_LATCH;
                    end else begin
                        counter_next = counter_reg - CNT_ONE;
                    end
                end
                S_LATCH: begin
                    a_level_next = 1'b1;
                    counter_next = LOAD2;
                    state_next   = S_WAIT2;
                end
                S_WAIT2: begin
                    // The pulse fires on the edge where the count reaches zero; a
                    // count already at zero (DELAY2=1) fires on the next edge.
                    if (a_fall) begin
                        state_next   = S_IDLE;
                        counter_next = '0;
                    end else if (counter_reg <= CNT_ONE) begin
                        counter_next  = '0;
                        e2_pulse_next = 1'b1;
                        finished_next = 1'b1;
                        state_next    = S_DONE;
                    end else begin
                        counter_next = counter_reg - CNT_ONE;
                    end
                end
                S_DONE: begin
                    if (start) begin
                        state_next    = S_ARM;
                        a_level_next  = 1'b0;
                        finished_next = 1'b0;
                    end
                end
                default: begin
                    state_next   = S_IDLE;
                    counter_next = '0;
                end
            endcase
        end

        busy_next = (state_next != S_IDLE) && (state_next != S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            counter_reg  <= '0;
            e1_pulse_reg <= 1'b0;
            e2_pulse_reg <= 1'b0;
            a_level_reg  <= 1'b0;
            a_prev_reg   <= 1'b0;
            finished_reg <= 1'b0;
            busy_reg     <= 1'b0;
            overrun_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            counter_reg  <= counter_next;
            e1_pulse_reg <= e1_pulse_next;
            e2_pulse_reg <= e2_pulse_next;
            a_level_reg  <= a_level_next;
            a_prev_reg   <= a_level_reg;
            finished_reg <= finished_next;
            busy_reg     <= busy_next;
            overrun_reg  <= overrun_next;
        end
    end

    assign e1_pulse = e1_pulse_reg;
    assign e2_pulse = e2_pulse_reg;
    assign a_level  = a_level_reg;
    assign finished = finished_reg;
    assign busy     = busy_reg;
    assign overrun  = overrun_reg;

    // A rising a_level can only appear on entry to WAIT2; the two pulses never overlap.
    a_no_overlap: assert property (@(posedge clk) disable iff (!rst_n)
        !(e1_pulse_reg && e2_pulse_reg));
    a_rise_in_wait2: assert property (@(posedge clk) disable iff (!rst_n)
        a_rise |-> (state_reg == S_WAIT2));

endmodule
